// File: rtl/sdp_unpack_arb.sv
// Burst-locked arbiter in front of the SDP unpack: one requester owns the datapath for RATIO beats.
// Define SDP_UNPACK_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sdp_unpack_arb #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int IW    = 128,
    parameter int RATIO = 4
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic [NREQ-1:0]    req_pvld,
    input  logic [NREQ*IW-1:0] req_data,
    output logic [NREQ-1:0]    req_prdy,
    output logic               out_pvld,
    output logic [IW-1:0]      out_data,
    input  logic               out_prdy,
    output logic [IDW-1:0]     out_src,
    output logic               out_last,
    output logic               arb_busy
);

    localparam int            CW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);
    localparam logic [IDW:0]  NREQ_W   = (IDW + 1)'(NREQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] lock_id, lock_id_nxt;
    logic [CW-1:0]  beat_cnt, beat_cnt_nxt;
    logic [IDW-1:0] rr_ptr, rr_ptr_nxt;

    logic           burst_act;
    logic           lk_vld;
    logic [IW-1:0]  lk_data;
    logic           accept;
    logic           last_beat;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] sel_ptr;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] rot;
    logic           win_found;
    logic [IDW-1:0] win_off;
    logic [IDW:0]   win_sum;
    logic [IDW-1:0] win_id;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state    <= IDLE;
            lock_id  <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            lock_id  <= lock_id_nxt;
            beat_cnt <= beat_cnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

    // Outputs are gated by reset so nothing leaks out during the reset cycle itself.
    assign burst_act = (state == BURST) && !nvdla_core_rst;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        lk_vld  = 1'b0;
        lk_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (lock_id == IDW'(i)) begin
                lk_vld  = req_pvld[i];
                lk_data = req_data[i*IW +: IW];
            end
        end
    end

    always_comb begin
        req_prdy = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_prdy[i] = burst_act && (lock_id == IDW'(i)) && out_prdy;
        end
    end

    assign out_pvld  = burst_act && lk_vld;
    assign out_data  = burst_act ? lk_data : '0;
    assign out_src   = burst_act ? lock_id : '0;
    assign out_last  = burst_act && (beat_cnt == LAST_CNT);
    assign arb_busy  = burst_act;

    assign accept    = out_pvld && out_prdy;
    assign last_beat = accept && (beat_cnt == LAST_CNT);
    assign next_ptr  = (lock_id == IDW'(NREQ - 1)) ? '0 : lock_id + IDW'(1);

`ifdef SDP_UNPACK_ARB_FIXED_PRIO_EN
    assign sel_ptr = '0;
    assign cand    = req_pvld;
`else
    assign sel_ptr = (state == BURST) ? next_ptr : rr_ptr;

    // The locked requester's valid on its last beat describes the beat being consumed, not a new request.
    always_comb begin
        cand = req_pvld;
        if (state == BURST) begin
            for (int i = 0; i < NREQ; i++) begin
                if (lock_id == IDW'(i)) cand[i] = 1'b0;
            end
        end
    end
`endif

    // Rotate so the scan starts at sel_ptr, take the lowest set bit, then rotate the index back.
    assign rot = NREQ'({cand, cand} >> sel_ptr);

    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_found = 1'b1;
                win_off   = IDW'(k);
            end
        end
        win_sum = {1'b0, sel_ptr} + {1'b0, win_off};
        if (win_sum >= NREQ_W) win_sum = win_sum - NREQ_W;
        win_id = win_sum[IDW-1:0];
    end

    always_comb begin
        state_nxt    = state;
        lock_id_nxt  = lock_id;
        beat_cnt_nxt = beat_cnt;
        rr_ptr_nxt   = rr_ptr;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt    = BURST;
                    lock_id_nxt  = win_id;
                    beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (last_beat) begin
                    beat_cnt_nxt = '0;
`ifndef SDP_UNPACK_ARB_FIXED_PRIO_EN
                    rr_ptr_nxt   = next_ptr;
`endif
                    if (win_found) lock_id_nxt = win_id;
                    else           state_nxt   = IDLE;
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdp_unpack_arb.sv
// Directed bench for sdp_unpack_arb: a per-cycle vector table plus a hand-written grant sequence
// that also drives a 2-requester RATIO=1 instance.
`timescale 1ns/1ps
module tb_sdp_unpack_arb;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int IW    = 128;
    localparam int RATIO = 4;

    localparam logic [7:0] BASE [NREQ] = '{8'hA0, 8'hB0, 8'h10, 8'hD0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [NREQ-1:0]    req_pvld;
    logic [NREQ*IW-1:0] req_data;
    logic [NREQ-1:0]    req_prdy;
    logic               out_pvld;
    logic [IW-1:0]      out_data;
    logic               out_prdy;
    logic [IDW-1:0]     out_src;
    logic               out_last;
    logic               arb_busy;

    logic [1:0]  s_pvld;
    logic [15:0] s_data;
    logic [1:0]  s_prdy;
    logic        s_opvld;
    logic [7:0]  s_odata;
    logic        s_src;
    logic        s_last;
    logic        s_busy;

    sdp_unpack_arb #(.NREQ(NREQ), .IDW(IDW), .IW(IW), .RATIO(RATIO)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .req_pvld       (req_pvld),
        .req_data       (req_data),
        .req_prdy       (req_prdy),
        .out_pvld       (out_pvld),
        .out_data       (out_data),
        .out_prdy       (out_prdy),
        .out_src        (out_src),
        .out_last       (out_last),
        .arb_busy       (arb_busy)
    );

    sdp_unpack_arb #(.NREQ(2), .IDW(1), .IW(8), .RATIO(1)) dut_r1 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .req_pvld       (s_pvld),
        .req_data       (s_data),
        .req_prdy       (s_prdy),
        .out_pvld       (s_opvld),
        .out_data       (s_odata),
        .out_prdy       (out_prdy),
        .out_src        (s_src),
        .out_last       (s_last),
        .arb_busy       (s_busy)
    );

    assign s_data = {8'h22, 8'h11};

    // Requester model: each requester presents BASE + number of its beats accepted so far.
    logic [7:0] cnt [NREQ];
    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) cnt[i] <= 8'd0;
            else if (req_pvld[i] && req_prdy[i]) cnt[i] <= cnt[i] + 8'd1;
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*IW +: IW] = {16{8'(BASE[i] + cnt[i])}};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] pvld;
        logic       prdy;
        logic       e_pvld;
        logic [1:0] e_src;
        logic       e_last;
        logic       e_busy;
        logic [3:0] e_rdy;
        logic [7:0] e_byte;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] p, input logic pr, input logic ep,
                       input logic [1:0] es, input logic el, input logic eb,
                       input logic [3:0] er, input logic [7:0] ebyte);
        vec_t v;
        v.rst = r; v.pvld = p; v.prdy = pr; v.e_pvld = ep; v.e_src = es;
        v.e_last = el; v.e_busy = eb; v.e_rdy = er; v.e_byte = ebyte;
        tbl.push_back(v);
    endtask

    task automatic quiet(input logic r, input logic [3:0] p);
        add(r, p, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
    endtask

    task automatic build_table();
        // Reset, then a lone requester 2 burst; busy drops right after its last beat.
        quiet(1'b1, 4'b0000);
        quiet(1'b1, 4'b0100);
        quiet(1'b0, 4'b0000);
        quiet(1'b0, 4'b0100);
        for (int k = 0; k < 4; k++) add(1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, k == 3, 1'b1, 4'b0100, 8'(8'h10 + k));
        quiet(1'b0, 4'b0000);
        // Round-robin with all four valid: 16 back-to-back beats, then requester 0 again.
        quiet(1'b1, 4'b0000);
        quiet(1'b0, 4'b1111);
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++)
                add(1'b0, 4'b1111, 1'b1, 1'b1, 2'(g), k == 3, 1'b1, 4'(1 << g), 8'(BASE[g] + k));
        add(1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0001, 8'hA4);
        // Lock under stall: requester 1 pauses for 3 cycles, requester 0 waits.
        quiet(1'b1, 4'b0000);
        quiet(1'b0, 4'b0010);
        add(1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 4'b0010, 8'hB0);
        add(1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 4'b0010, 8'hB1);
        for (int k = 0; k < 3; k++) add(1'b0, 4'b0001, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 4'b0010, 8'h00);
        add(1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 4'b0010, 8'hB2);
        add(1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0010, 8'hB3);
        add(1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0001, 8'hA0);
        // Backpressure 1,0,0 pattern on requester 2.
        quiet(1'b1, 4'b0000);
        quiet(1'b0, 4'b0100);
        add(1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 4'b0100, 8'h10);
        for (int k = 1; k < 4; k++) begin
            add(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, k == 3, 1'b1, 4'b0000, 8'(8'h10 + k));
            add(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, k == 3, 1'b1, 4'b0000, 8'(8'h10 + k));
            add(1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, k == 3, 1'b1, 4'b0100, 8'(8'h10 + k));
        end
        quiet(1'b0, 4'b0000);
        // Pointer now 3: requester 3 starts, reset hits after 2 beats, pointer returns to 0.
        quiet(1'b0, 4'b1000);
        add(1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 4'b1000, 8'hD0);
        add(1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 4'b1000, 8'hD1);
        quiet(1'b1, 4'b1000);
        quiet(1'b0, 4'b0000);
        quiet(1'b0, 4'b1001);
        for (int k = 0; k < 4; k++) add(1'b0, 4'b1001, 1'b1, 1'b1, 2'd0, k == 3, 1'b1, 4'b0001, 8'(8'hA0 + k));
        for (int k = 0; k < 4; k++) add(1'b0, 4'b1001, 1'b1, 1'b1, 2'd3, k == 3, 1'b1, 4'b1000, 8'(8'hD0 + k));
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0001, 8'h00);
        quiet(1'b1, 4'b0000);
    endtask

    logic [1:0] exp_burst [3];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        req_pvld = '0;
        out_prdy = 1'b1;
        s_pvld   = '0;
`ifdef SDP_UNPACK_ARB_FIXED_PRIO_EN
        exp_burst = '{2'd0, 2'd0, 2'd0};
`else
        exp_burst = '{2'd0, 2'd2, 2'd0};
`endif

`ifndef SDP_UNPACK_ARB_FIXED_PRIO_EN
        build_table();
        for (int i = 0; i < tbl.size(); i++) begin
            rst      = tbl[i].rst;
            req_pvld = tbl[i].pvld;
            out_prdy = tbl[i].prdy;
            @(negedge clk);
            check($sformatf("row%0d out_pvld", i), out_pvld, tbl[i].e_pvld);
            check($sformatf("row%0d out_src", i),  out_src,  tbl[i].e_src);
            check($sformatf("row%0d out_last", i), out_last, tbl[i].e_last);
            check($sformatf("row%0d arb_busy", i), arb_busy, tbl[i].e_busy);
            check($sformatf("row%0d req_prdy", i), req_prdy, tbl[i].e_rdy);
            if (tbl[i].e_pvld)
                check($sformatf("row%0d out_data", i), out_data, {16{tbl[i].e_byte}});
            @(posedge clk);
            #1;
        end
`endif

        // Requesters 0 and 2 held valid for three bursts; the RATIO=1 instance rotates every beat.
        rst      = 1'b1;
        req_pvld = '0;
        s_pvld   = '0;
        out_prdy = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        req_pvld = 4'b0101;
        s_pvld   = 2'b11;
        @(negedge clk);
        check("seq idle arb_busy", arb_busy, 1'b0);
        check("seq idle r1 busy", s_busy, 1'b0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 12; c++) begin
            logic [1:0] es;
            logic       es1;
            es = exp_burst[c / 4];
`ifdef SDP_UNPACK_ARB_FIXED_PRIO_EN
            es1 = 1'b0;
`else
            es1 = 1'(c % 2);
`endif
            @(negedge clk);
            check($sformatf("seq c%0d out_src", c), out_src, es);
            check($sformatf("seq c%0d out_pvld", c), out_pvld, 1'b1);
            check($sformatf("seq c%0d out_last", c), out_last, (c % 4) == 3);
            check($sformatf("seq c%0d req_prdy2", c), req_prdy[2], es == 2'd2);
            check($sformatf("seq c%0d r1 src", c), s_src, es1);
            check($sformatf("seq c%0d r1 last", c), s_last, 1'b1);
            check($sformatf("seq c%0d r1 data", c), s_odata, es1 ? 8'h22 : 8'h11);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
